// File: rtl/dmem_srq_param.sv
// dmem_srq_param
// Shift-register-queue store for the intermediate value D of a layered LDPC
// decoder. There is one queue per layer, each DEPTH entries deep. An entry is
// one full P-row slice across all NB circulants at weight WT, so the entry
// width is DW = P*NB*WT*W.
//
// A write pushes wr_data onto the young end (address DEPTH-1) of queue
// wr_layer and drops the oldest entry (address 0). A read is registered: a
// request at edge N returns its data with rd_valid at edge N+1. The read
// samples the contents as they were before any write at the same edge.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   clr         synchronous clear of all fill counters (data untouched)
//   wr_en       push wr_data into queue wr_layer
//   wr_layer    target queue; values >= LAYERS are ignored
//   wr_data     packed {rpu P-1..0}{circ NB-1..0}{WT values of W bits}
//   rd_en       read request
//   rd_layer    queue to read
//   rd_address  entry index within the queue (0 = oldest retained)
//   rd_data     registered read data, same packing as wr_data
//   rd_valid    one-cycle strobe qualifying rd_data
//   rd_err      one-cycle strobe: the request was out of range
//   full        bit L is high while queue L holds DEPTH entries
//   wr_ovf      one-cycle strobe: a write landed on a full queue
module dmem_srq_param #(
  parameter int W       = 6,
  parameter int P       = 26,
  parameter int NB      = 16,
  parameter int WT      = 2,
  parameter int DEPTH   = 20,
  parameter int LAYERS  = 2,
  parameter int ADDR_W  = 5,
  parameter int LAYER_W = 1,
  localparam int DW     = P * NB * WT * W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [LAYER_W-1:0] wr_layer,
  input  logic [DW-1:0]      wr_data,
  input  logic               rd_en,
  input  logic [LAYER_W-1:0] rd_layer,
  input  logic [ADDR_W-1:0]  rd_address,
  output logic [DW-1:0]      rd_data,
  output logic               rd_valid,
  output logic               rd_err,
  output logic [LAYERS-1:0]  full,
  output logic               wr_ovf
);

  // Index widths sized to the arrays. The address and layer ports are at least
  // this wide, so the range checks are done on the full port value first and
  // the low bits are used only after a check has passed.
  localparam int AIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LIDX_W = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [ADDR_W:0]    DEPTH_C   = (ADDR_W + 1)'(DEPTH);
  localparam logic [LAYER_W:0]   LAYERS_C  = (LAYER_W + 1)'(LAYERS);

  logic [DW-1:0]    mem   [LAYERS][DEPTH];
  logic [CNT_W-1:0] count [LAYERS];

  logic              wr_hit;
  logic              rd_ok;
  logic [LIDX_W-1:0] wr_lidx;
  logic [LIDX_W-1:0] rd_lidx;
  logic [AIDX_W-1:0] rd_aidx;

  assign wr_hit  = wr_en && ({1'b0, wr_layer} < LAYERS_C);
  assign rd_ok   = ({1'b0, rd_layer} < LAYERS_C) && ({1'b0, rd_address} < DEPTH_C);
  assign wr_lidx = wr_layer[LIDX_W-1:0];
  assign rd_lidx = rd_layer[LIDX_W-1:0];
  assign rd_aidx = rd_address[AIDX_W-1:0];

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    full = '0;
    for (int l = 0; l < LAYERS; l++) begin
      full[l] = (count[l] == CNT_FULL);
    end
  end

  // Queue storage. The shift happens on every accepted write, including one
  // made together with clr or onto a full queue.
  // NOTE: this storage array is reset on purpose, because reset must leave every entry readable as zero; that makes it flops, not a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int l = 0; l < LAYERS; l++) begin
        for (int k = 0; k < DEPTH; k++) begin
          mem[l][k] <= '0;
        end
      end
    end else if (wr_hit) begin
      for (int l = 0; l < LAYERS; l++) begin
        if (wr_lidx == LIDX_W'(l)) begin
          for (int k = 0; k < DEPTH - 1; k++) begin
            // NOTE: non-blocking assignment, so each stage takes its neighbour's pre-edge value and the shift does not ripple.
            mem[l][k] <= mem[l][k+1];
          end
          mem[l][DEPTH-1] <= wr_data;
        end
      end
    end
  end

  // Fill counters and overflow strobe. When clr arrives with a write, the
  // clear wins, the write then counts as one entry, and no overflow is flagged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int l = 0; l < LAYERS; l++) begin
        count[l] <= '0;
      end
      wr_ovf <= 1'b0;
    end else begin
      wr_ovf <= wr_hit && !clr && (count[wr_lidx] == CNT_FULL);
      for (int l = 0; l < LAYERS; l++) begin
        if (wr_hit && (wr_lidx == LIDX_W'(l))) begin
          if (clr) begin
            count[l] <= CNT_W'(1);
          end else if (count[l] != CNT_FULL) begin
            count[l] <= count[l] + CNT_W'(1);
          end
        end else if (clr) begin
          count[l] <= '0;
        end
      end
    end
  end

  // Registered read port. Because mem is read here before its own update, a
  // read and a write to the same queue at one edge return the old contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else if (rd_en) begin
      rd_valid <= 1'b1;
      if (rd_ok) begin
        rd_data <= mem[rd_lidx][rd_aidx];
        rd_err  <= 1'b0;
      end else begin
        rd_data <= '0;
        rd_err  <= 1'b1;
      end
    end else begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_srq_param.sv
module tb_dmem_srq_param;

  localparam int W       = 4;
  localparam int P       = 2;
  localparam int NB      = 2;
  localparam int WT      = 1;
  localparam int DEPTH   = 4;
  localparam int LAYERS  = 2;
  localparam int ADDR_W  = 3;
  localparam int LAYER_W = 2;
  localparam int DW      = P * NB * WT * W;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clr;
  logic               wr_en;
  logic [LAYER_W-1:0] wr_layer;
  logic [DW-1:0]      wr_data;
  logic               rd_en;
  logic [LAYER_W-1:0] rd_layer;
  logic [ADDR_W-1:0]  rd_address;
  logic [DW-1:0]      rd_data;
  logic               rd_valid;
  logic               rd_err;
  logic [LAYERS-1:0]  full;
  logic               wr_ovf;

  dmem_srq_param #(
    .W(W), .P(P), .NB(NB), .WT(WT), .DEPTH(DEPTH),
    .LAYERS(LAYERS), .ADDR_W(ADDR_W), .LAYER_W(LAYER_W)
  ) dut (
    .clk(clk), .rst(rst_n), .clr(clr),
    .wr_en(wr_en), .wr_layer(wr_layer), .wr_data(wr_data),
    .rd_en(rd_en), .rd_layer(rd_layer), .rd_address(rd_address),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
    .full(full), .wr_ovf(wr_ovf)
  );

  always #5 clk = ~clk;

  // Reference model: each layer is a FIFO of the retained entries, oldest at
  // the front, always exactly DEPTH long (zero-filled after reset).
  logic [DW-1:0] mq [LAYERS][$];
  int            cnt [LAYERS];
  logic [DW-1:0] exp_data;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < LAYERS; l++) begin
      mq[l].delete();
      repeat (DEPTH) mq[l].push_back('0);
      cnt[l] = 0;
    end
    exp_data = '0;
  endtask

  function automatic logic [LAYERS-1:0] exp_full();
    logic [LAYERS-1:0] f = '0;
    for (int l = 0; l < LAYERS; l++) f[l] = (cnt[l] == DEPTH);
    return f;
  endfunction

  // One clock cycle: drive, predict from the pre-edge model, clock, check.
  task automatic step(input logic we, input int wl, input logic [DW-1:0] wd,
                      input logic re, input int rl, input int ra,
                      input logic c, input string tag);
    logic hit, e_err, e_ovf;
    wr_en = we; wr_layer = LAYER_W'(wl); wr_data = wd;
    rd_en = re; rd_layer = LAYER_W'(rl); rd_address = ADDR_W'(ra);
    clr = c;
    e_err = re && (rl >= LAYERS || ra >= DEPTH);
    if (re) exp_data = e_err ? '0 : mq[rl][ra];
    hit   = we && (wl < LAYERS);
    e_ovf = hit && !c && (cnt[wl] == DEPTH);
    if (c) for (int l = 0; l < LAYERS; l++) cnt[l] = 0;
    if (hit) begin
      mq[wl].push_back(wd);
      void'(mq[wl].pop_front());
      cnt[wl] = (cnt[wl] < DEPTH) ? cnt[wl] + 1 : DEPTH;
    end
    @(posedge clk);
    #1;
    chk({tag, " rd_valid"}, 32'(rd_valid), 32'(re));
    chk({tag, " rd_err"},   32'(rd_err),   32'(e_err));
    chk({tag, " rd_data"},  32'(rd_data),  32'(exp_data));
    chk({tag, " wr_ovf"},   32'(wr_ovf),   32'(e_ovf));
    chk({tag, " full"},     32'(full),     32'(exp_full()));
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_layer = '0; wr_data = '0;
    rd_en = 1'b0; rd_layer = '0; rd_address = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset rd_valid", 32'(rd_valid), 32'd0);
    chk("reset full",     32'(full),     32'd0);
    rst_n = 1'b1;

    // 1: read after reset gives zero
    step(0, 0, '0, 1, 0, 0, 0, "s1 read0");

    // 2: fill L0, read back oldest to youngest
    step(1, 0, 16'h1111, 0, 0, 0, 0, "s2 w1");
    step(1, 0, 16'h2222, 0, 0, 0, 0, "s2 w2");
    step(1, 0, 16'h3333, 0, 0, 0, 0, "s2 w3");
    step(1, 0, 16'h4444, 0, 0, 0, 0, "s2 w4");
    for (int a = 0; a < DEPTH; a++) step(0, 0, '0, 1, 0, a, 0, $sformatf("s2 rd%0d", a));

    // 3: overflow write on full L0
    step(1, 0, 16'h5555, 0, 0, 0, 0, "s3 ovf");
    step(0, 0, '0, 1, 0, 0, 0, "s3 rd0");
    step(0, 0, '0, 1, 0, 3, 0, "s3 rd3");

    // 4: read-before-write on the same layer; L1 untouched
    step(1, 0, 16'hAAAA, 1, 0, 3, 0, "s4 rbw");
    step(0, 0, '0, 1, 0, 3, 0, "s4 rd3");
    step(0, 0, '0, 1, 1, 3, 0, "s4 l1");

    // 5: out-of-range reads and an ignored write to a missing layer
    step(0, 0, '0, 1, 0, 4, 0, "s5 addr4");
    step(0, 0, '0, 1, 1, 7, 0, "s5 addr7");
    step(1, 2, 16'hBEEF, 1, 2, 0, 0, "s5 layer2");
    step(0, 0, '0, 1, 3, 1, 0, "s5 layer3");
    step(0, 0, '0, 0, 0, 0, 0, "s5 idle");

    // 6: clr with a write to L1, then reset during a pending read
    step(1, 1, 16'h7777, 0, 0, 0, 1, "s6 clr");
    for (int i = 0; i < DEPTH - 2; i++) step(1, 1, 16'h0100 + 16'(i), 0, 0, 0, 0, "s6 fill");
    step(1, 1, 16'h0999, 1, 1, 3, 0, "s6 l1full");

    // random traffic against the model
    for (int n = 0; n < 300; n++) begin
      step($urandom_range(0, 1), $urandom_range(0, 3), 16'($urandom),
           $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7),
           ($urandom_range(0, 15) == 0), "rnd");
    end

    step(0, 0, '0, 1, 0, 3, 0, "s6 pre");
    rd_en = 1'b1; rd_layer = '0; rd_address = '0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst rd_valid", 32'(rd_valid), 32'd0);
    chk("rst rd_data",  32'(rd_data),  32'd0);
    chk("rst rd_err",   32'(rd_err),   32'd0);
    chk("rst full",     32'(full),     32'd0);
    chk("rst wr_ovf",   32'(wr_ovf),   32'd0);
    rd_en = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(0, 0, '0, 0, 0, 0, 0, "post rst");
    step(0, 0, '0, 1, 0, 3, 0, "post rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_srq_param.md
Name: dmem_srq_param

Overview:
- Parametrised shift-register-queue memory for the intermediate value D: the relative difference between extrinsic messages of a row across iterations.
- Holds one queue per layer, each DEPTH entries deep. Each entry is one full P-row slice across all NB circulants at weight WT.
- Generalises the fixed 26-row, 16-circulant, 2-layer, 20-cycle store. Adds configurable depth and layer count, per-layer fill tracking, full/overflow reporting, out-of-range read detection and a registered read with a valid strobe.
- Sits between the row calculation units and the layer scheduler in the layered LDPC decoder.

Parameters:
- W, 6, bits per D value
- P, 26, rows processed per cycle
- NB, 16, circulant blocks per layer
- WT, 2, circulant weight
- DEPTH, 20, entries per layer queue (ceil(Z/P))
- LAYERS, 2, number of layer queues
- ADDR_W, 5, read address width; must satisfy 2^ADDR_W >= DEPTH
- LAYER_W, 1, layer select width; must satisfy 2^LAYER_W >= LAYERS
- Derived, not overridable: DW = P*NB*WT*W, the entry width.

Ports:
- clk, in, 1, rising-edge clock
- rst, in, 1, asynchronous active-low reset
- clr, in, 1, synchronous clear of all fill counters
- wr_en, in, 1, push wr_data into queue wr_layer
- wr_layer, in, LAYER_W, target queue for a write
- wr_data, in, DW, packed {rpu P-1 .. rpu 0}; each rpu field is {circ NB-1 .. circ 0}; each circ field is WT values of W bits
- rd_en, in, 1, read request
- rd_layer, in, LAYER_W, queue to read
- rd_address, in, ADDR_W, entry index within the queue (0 = oldest retained)
- rd_data, out, DW, registered read data, same packing as wr_data
- rd_valid, out, 1, one-cycle strobe qualifying rd_data
- rd_err, out, 1, one-cycle strobe: read request was out of range
- full, out, LAYERS, bit L high when queue L holds DEPTH entries
- wr_ovf, out, 1, one-cycle strobe: a write was made to a full queue

Behaviour:
- Reset (rst=0, asynchronous): all storage, rd_data, fill counters, rd_valid, rd_err, wr_ovf and full are 0.
- Write, on a clk edge with wr_en=1 and wr_layer<LAYERS:
  - queue[wr_layer][k] <= queue[wr_layer][k+1] for k<DEPTH-1, and queue[wr_layer][DEPTH-1] <= wr_data.
  - After exactly DEPTH writes since clear, address a holds the a-th write (0-based).
- Fill counter per layer, 0..DEPTH:
  - increments on each write and saturates at DEPTH;
  - full[L] = (count[L]==DEPTH).
- Write when already full: the shift still occurs (oldest entry discarded), the count stays at DEPTH, and wr_ovf=1 on the next cycle.
- wr_layer>=LAYERS: the write is ignored; no state change, no ovf.
- Read: if rd_en=1 at edge N, then at edge N+1:
  - rd_data = queue[rd_layer][rd_address] as sampled before any write at edge N;
  - rd_valid=1 for one cycle.
  - Latency is 1 cycle. Back-to-back reads are allowed every cycle.
- Out-of-range read (rd_address>=DEPTH or rd_layer>=LAYERS): rd_data <= 0, rd_valid=1, rd_err=1.
- Read of an address not yet written since clr: returns stale contents, with no error. Tracking valid data is the scheduler's job.
- rd_en=0: rd_data holds its value; rd_valid=0 and rd_err=0.
- Simultaneous read and write to the same layer: the read sees the pre-shift contents (read-before-write).
- Simultaneous reads and writes to different layers are independent.
- clr=1: all counters go to 0 and full goes to 0 at the next edge. Data is untouched.
  - clr together with wr_en: the clear takes priority, and the write then counts as 1.
  - The data shift still occurs.
- Reset asserted mid-read: rd_valid drops immediately; no pending response is issued after release.
- Data transport is bit-exact: no arithmetic or saturation is performed on D values.

Test Plan:
All scenarios use bench parameters W=4, P=2, NB=2, WT=1, DEPTH=4, LAYERS=2, ADDR_W=3, so DW=16.
1. Reset, then read L0 addr 0 -> after 1 cycle rd_data=16'h0000, rd_valid=1, rd_err=0; full=2'b00.
2. Write 16'h1111, 16'h2222, 16'h3333, 16'h4444 to L0, then read addr 0..3 back-to-back -> rd_data = 1111, 2222, 3333, 4444 on consecutive cycles; full=2'b01 after the 4th write.
3. From the full L0 of scenario 2, write 16'h5555 -> wr_ovf pulses once; addr 0 now reads 2222 and addr 3 reads 5555; full[0] stays 1.
4. In the same cycle, read L0 addr 3 and write 16'hAAAA to L0 -> rd_data=5555 (old). The next read of addr 3 gives AAAA. L1 is unchanged, still 0000.
5. Read addr 4 or rd_layer=... out-of-range cases -> rd_data=0000, rd_valid=1, rd_err=1 for one cycle.
6. Assert clr together with wr_en to L1 -> full=00 and the L1 count is 1. Then pull rst low while a read is pending -> rd_valid=0 immediately and all outputs are 0.
